// File: rtl/wb_stage_pkg.sv
// Shared encodings for the writeback stage: source-select codes, FSM states, default widths.
package wb_stage_pkg;

    localparam int DEFAULT_XLEN = 32;

    typedef logic [2:0] wb_sel_t;

    localparam wb_sel_t WB_ALU    = 3'd0;
    localparam wb_sel_t WB_LU     = 3'd1;
    localparam wb_sel_t WB_IMM    = 3'd2;
    localparam wb_sel_t WB_CSR    = 3'd3;
    localparam wb_sel_t WB_PC4    = 3'd4;
    localparam wb_sel_t WB_IADDER = 3'd5;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_LOAD_WAIT = 1'b1
    } wb_state_e;

endpackage

// File: rtl/wb_src_mux.sv
// Combinational writeback source select, zero latency, no backpressure; unknown codes fall back to ALU.
// CSR source only present when WB_CSR_EN is defined, otherwise code 3 also selects ALU.
module wb_src_mux
    import wb_stage_pkg::*;
#(
    parameter int XLEN = DEFAULT_XLEN
) (
    input  logic [2:0]      sel_i,
    input  logic [XLEN-1:0] alu_i,
    input  logic [XLEN-1:0] lu_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] csr_i,
    input  logic [XLEN-1:0] pc4_i,
    input  logic [XLEN-1:0] iadder_i,
    output logic [XLEN-1:0] data_o
);

`ifndef WB_CSR_EN
    logic unused_csr;
    assign unused_csr = ^csr_i;
`endif

    always_comb begin
        data_o = alu_i;
        case (sel_i)
            WB_LU:     data_o = lu_i;
            WB_IMM:    data_o = imm_i;
`ifdef WB_CSR_EN
            WB_CSR:    data_o = csr_i;
`else
            WB_CSR:    data_o = alu_i;
`endif
            WB_PC4:    data_o = pc4_i;
            WB_IADDER: data_o = iadder_i;
            default:   data_o = alu_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered RV32I writeback: 1-cycle latency, 1/cycle throughput; loads hold in_ready_out low until lu_valid_in.
// Registered write port also serves as the forwarding source; macro WB_CSR_EN enables the CSR source.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int XLEN      = DEFAULT_XLEN,
    parameter int RF_ADDR_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 flush_in,
    input  logic                 in_valid_in,
    output logic                 in_ready_out,
    input  logic [2:0]           wb_sel_in,
    input  logic [RF_ADDR_W-1:0] rd_addr_in,
    input  logic                 rd_wr_en_in,
    input  logic [XLEN-1:0]      alu_result_in,
    input  logic [XLEN-1:0]      imm_in,
    input  logic [XLEN-1:0]      csr_data_in,
    input  logic [XLEN-1:0]      pc_plus_4_in,
    input  logic [XLEN-1:0]      iadder_out_in,
    input  logic                 lu_valid_in,
    input  logic [XLEN-1:0]      lu_data_in,
    output logic                 rf_wr_en_out,
    output logic [RF_ADDR_W-1:0] rf_addr_out,
    output logic [XLEN-1:0]      rf_data_out,
    output logic [CNT_W-1:0]     retire_cnt_out
);

    wb_state_e              state_q, state_d;
    logic                   wr_en_q, wr_en_d;
    logic [RF_ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]        data_q, data_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RF_ADDR_W-1:0]   ld_addr_q, ld_addr_d;
    logic                   ld_we_q, ld_we_d;

    logic [XLEN-1:0]        src_data;
    logic                   accept;
    logic                   we_eff;

    wb_src_mux #(.XLEN(XLEN)) u_src_mux (
        .sel_i    (wb_sel_in),
        .alu_i    (alu_result_in),
        .lu_i     (lu_data_in),
        .imm_i    (imm_in),
        .csr_i    (csr_data_in),
        .pc4_i    (pc_plus_4_in),
        .iadder_i (iadder_out_in),
        .data_o   (src_data)
    );

    assign in_ready_out = (state_q == ST_IDLE) && !flush_in;
    assign accept       = in_valid_in && in_ready_out;
    // x0 is hardwired to zero, so a write to it is dropped but still retires.
    assign we_eff       = rd_wr_en_in && (rd_addr_in != '0);

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        ld_addr_d = ld_addr_q;
        ld_we_d   = ld_we_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (wb_sel_in == WB_LU) begin
                        ld_addr_d = rd_addr_in;
                        ld_we_d   = we_eff;
                        state_d   = ST_LOAD_WAIT;
                    end else begin
                        wr_en_d = we_eff;
                        if (we_eff) begin
                            addr_d = rd_addr_in;
                            data_d = src_data;
                        end
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LOAD_WAIT: begin
                // A flush kills the load even if its data arrives in the same cycle.
                if (flush_in) begin
                    state_d = ST_IDLE;
                end else if (lu_valid_in) begin
                    wr_en_d = ld_we_q;
                    if (ld_we_q) begin
                        addr_d = ld_addr_q;
                        data_d = lu_data_in;
                    end
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            cnt_q     <= '0;
            ld_addr_q <= '0;
            ld_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            ld_addr_q <= ld_addr_d;
            ld_we_q   <= ld_we_d;
        end
    end

    assign rf_wr_en_out   = wr_en_q;
    assign rf_addr_out    = addr_q;
    assign rf_data_out    = data_q;
    assign retire_cnt_out = cnt_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed plus random stimulus for wb_stage, checked against a transaction-level reference model.
module tb_wb_stage;

    localparam int CNT_W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  sel = 3'd0;
    logic [4:0]  rd = 5'd0;
    logic        rd_we = 1'b0;
    logic [31:0] alu = 0, imm = 0, csr = 0, pc4 = 0, iadd = 0, lud = 0;
    logic        luv = 1'b0;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic [CNT_W-1:0] rcnt;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: a pending load (if any) and the last completed write.
    bit          m_pending = 0;
    logic [4:0]  m_ld_rd = 0;
    bit          m_ld_we = 0;
    bit          m_we = 0;
    logic [4:0]  m_addr = 0;
    logic [31:0] m_data = 0;
    int          m_retired = 0;

    wb_stage #(.XLEN(32), .RF_ADDR_W(5), .CNT_W(CNT_W)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .flush_in       (flush),
        .in_valid_in    (in_valid),
        .in_ready_out   (in_ready),
        .wb_sel_in      (sel),
        .rd_addr_in     (rd),
        .rd_wr_en_in    (rd_we),
        .alu_result_in  (alu),
        .imm_in         (imm),
        .csr_data_in    (csr),
        .pc_plus_4_in   (pc4),
        .iadder_out_in  (iadd),
        .lu_valid_in    (luv),
        .lu_data_in     (lud),
        .rf_wr_en_out   (rf_we),
        .rf_addr_out    (rf_addr),
        .rf_data_out    (rf_data),
        .retire_cnt_out (rcnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] expected_src(input logic [2:0] s);
        logic [31:0] table_v [8];
        table_v = '{alu, lud, imm, alu, pc4, iadd, alu, alu};
`ifdef WB_CSR_EN
        table_v[3] = csr;
`endif
        return table_v[s];
    endfunction

    task automatic clr();
        in_valid = 0; luv = 0; flush = 0; rd_we = 0; sel = 0; rd = 0;
    endtask

    task automatic issue(input logic [2:0] s, input logic [4:0] r, input bit we);
        in_valid = 1; sel = s; rd = r; rd_we = we;
    endtask

    // One clock: check in_ready against the inputs just driven, advance the model, check registered outputs.
    task automatic tick();
        bit rdy_exp;
        bit nothing_written;
        #1;
        rdy_exp = !m_pending && !flush;
        chk("in_ready", {31'd0, in_ready}, {31'd0, rdy_exp});
        nothing_written = 1;
        m_we = 0;
        if (m_pending) begin
            if (flush) begin
                m_pending = 0;
            end else if (luv) begin
                m_pending = 0;
                m_retired++;
                if (m_ld_we) begin
                    m_we = 1; m_addr = m_ld_rd; m_data = lud;
                end
            end
        end else if (in_valid && rdy_exp) begin
            if (sel == 3'd1) begin
                m_pending = 1; m_ld_rd = rd; m_ld_we = rd_we && (rd != 0);
            end else begin
                m_retired++;
                if (rd_we && rd != 0) begin
                    m_we = 1; m_addr = rd; m_data = expected_src(sel);
                end
            end
        end
        nothing_written = !m_we;
        @(posedge clk);
        @(negedge clk);
        chk("rf_wr_en", {31'd0, rf_we}, {31'd0, m_we});
        chk("retire_cnt", {24'd0, rcnt}, 32'(m_retired % (1 << CNT_W)));
        if (!nothing_written) begin
            chk("rf_addr", {27'd0, rf_addr}, {27'd0, m_addr});
            chk("rf_data", rf_data, m_data);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"}, {31'd0, rf_we}, 32'd0);
        chk({tag, "_addr"}, {27'd0, rf_addr}, 32'd0);
        chk({tag, "_data"}, rf_data, 32'd0);
        chk({tag, "_cnt"}, {24'd0, rcnt}, 32'd0);
        chk({tag, "_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        // Reset state
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Single ALU writeback
        issue(3'd0, 5'd5, 1); alu = 32'h1234;
        tick();
        clr();
        tick();

        // Back-to-back PC+4 then IMM
        issue(3'd4, 5'd1, 1); pc4 = 32'h104;
        tick();
        issue(3'd2, 5'd2, 1); imm = 32'hFFFFF000;
        tick();
        clr();
        tick();

        // Load with data three cycles later
        issue(3'd1, 5'd7, 1);
        tick();
        clr();
        repeat (2) tick();
        luv = 1; lud = 32'hDEADBEEF;
        tick();
        clr();
        tick();

        // Flush wins over simultaneous load data
        issue(3'd1, 5'd9, 1);
        tick();
        clr();
        flush = 1; luv = 1; lud = 32'h55AA55AA;
        tick();
        clr();
        tick();

        // lu_valid while idle is ignored; flush in idle blocks acceptance
        luv = 1; lud = 32'h0BAD0BAD;
        tick();
        clr();
        issue(3'd0, 5'd6, 1); flush = 1; alu = 32'h77;
        tick();
        clr();

        // x0 write suppressed but retired, then sel 6 maps to ALU
        issue(3'd6, 5'd0, 1); alu = 32'hCAFE0000;
        tick();
        issue(3'd6, 5'd3, 1); alu = 32'h00C0FFEE;
        tick();
        issue(3'd7, 5'd8, 0); alu = 32'h1;
        tick();

        // CSR select
        issue(3'd3, 5'd4, 1); csr = 32'hABCD; alu = 32'h9999;
        tick();
        clr();
        tick();

        // Reset in the middle of a pending load
        issue(3'd1, 5'd10, 1);
        tick();
        clr();
        tick();
        #2;
        rst_n = 0;
        #1;
        m_pending = 0; m_retired = 0; m_addr = 0; m_data = 0; m_we = 0;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check_reset_outputs("postreset");

        // Random traffic; enough retirements to wrap the narrow counter
        for (int i = 0; i < 1200; i++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            sel      = 3'($urandom_range(0, 7));
            rd       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            rd_we    = ($urandom_range(0, 4) != 0);
            alu  = $urandom; imm = $urandom; csr = $urandom;
            pc4  = $urandom; iadd = $urandom; lud = $urandom;
            luv   = ($urandom_range(0, 2) == 0);
            flush = ($urandom_range(0, 15) == 0);
            tick();
        end
        clr();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
